roce_front_end: RTL and testbench

- Request-intake stage of the ROCE memory controller. Sits between the upstream requester and the back-end scheduler.
- Accepts read/write requests into two 64-entry tracking tables and issues pending requests one at a time to the back end under a grant handshake.
- Retires entries on completion notifications and returns read data upstream.

---
 rtl/roce_front_end_if.sv | 34 +++
 rtl/roce_front_end.sv | 150 +++++++++++++++
 tb/tb_roce_front_end.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/roce_front_end_if.sv
// Request, issue and completion signals of the ROCE front end.
// The slave modport is the front end itself; the master modport is the requester/back-end side.
interface roce_front_end_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6
);
    logic                              in_valid;
    logic                              in_request_type;
    logic [DATA_W-1:0]                 in_request_data;
    logic [ADDR_W-1:0]                 in_request_address;
    logic [1:0]                        out_busy;
    logic                              grant_i;
    logic [1+1+IDX_W+DATA_W+ADDR_W-1:0] out;
    logic                              request_done_valid;
    logic                              the_type;
    logic [IDX_W-1:0]                  index;
    logic [DATA_W-1:0]                 data_in;
    logic                              read_done;
    logic                              write_done;
    logic [DATA_W-1:0]                 data_out;

    modport slave (
        input  in_valid, in_request_type, in_request_data, in_request_address,
        input  grant_i, request_done_valid, the_type, index, data_in,
        output out_busy, out, read_done, write_done, data_out
    );

    modport master (
        output in_valid, in_request_type, in_request_data, in_request_address,
        output grant_i, request_done_valid, the_type, index, data_in,
        input  out_busy, out, read_done, write_done, data_out
    );
endinterface

// File: rtl/roce_front_end.sv
// ROCE front end: read and write tracking tables, lowest-index issue (reads first)
// under a grant handshake, and retirement on completion notifications.
module roce_front_end #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64
) (
    input logic             clk,
    input logic             rst_n,
    roce_front_end_if.slave bus
);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int REQ_SIZE = 1 + DATA_W + ADDR_W;
    localparam int OUT_W    = 1 + IDX_W + REQ_SIZE;

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ISSUED  = 2'd2
    } entry_state_e;

    // Table 0 holds reads, table 1 holds writes; the table implies the request type.
    entry_state_e      state_r     [2][DEPTH];
    entry_state_e      state_nxt_s [2][DEPTH];
    logic [DATA_W-1:0] data_r      [2][DEPTH];
    logic [ADDR_W-1:0] addr_r      [2][DEPTH];

    logic [1:0]        free_found_s;
    logic [1:0]        pend_found_s;
    logic [IDX_W-1:0]  free_idx_s [2];
    logic [IDX_W-1:0]  pend_idx_s [2];
    logic [1:0]        accept_s;
    logic [1:0]        issue_s;
    logic [1:0]        comp_s;
    logic              load_s;
    logic [OUT_W-1:0]  out_r;
    logic [OUT_W-1:0]  out_nxt_s;
    logic              read_done_r;
    logic              write_done_r;
    logic [DATA_W-1:0] data_out_r;

    // Lowest-index FREE and PENDING entry of each table.
    always_comb begin
        for (int t = 0; t < 2; t++) begin
            free_found_s[t] = 1'b0;
            free_idx_s[t]   = {IDX_W{1'b0}};
            pend_found_s[t] = 1'b0;
            pend_idx_s[t]   = {IDX_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                if (!free_found_s[t] && (state_r[t][i] == ST_FREE)) begin
                    free_found_s[t] = 1'b1;
                    free_idx_s[t]   = IDX_W'(i);
                end else begin
                    free_found_s[t] = free_found_s[t];
                end
                if (!pend_found_s[t] && (state_r[t][i] == ST_PENDING)) begin
                    pend_found_s[t] = 1'b1;
                    pend_idx_s[t]   = IDX_W'(i);
                end else begin
                    pend_found_s[t] = pend_found_s[t];
                end
            end
        end
    end

    // Accept, issue and completion decisions, all taken from registered state.
    always_comb begin
        load_s = ~out_r[OUT_W-1] | bus.grant_i;
        for (int t = 0; t < 2; t++) begin
            accept_s[t] = bus.in_valid & (bus.in_request_type == 1'(t)) & free_found_s[t];
            comp_s[t]   = bus.request_done_valid & (bus.the_type == 1'(t)) &
                          (state_r[t][bus.index] == ST_ISSUED);
        end
        issue_s[0] = load_s & pend_found_s[0];
        issue_s[1] = load_s & ~pend_found_s[0] & pend_found_s[1];
    end

    // Next issue word: reads have priority; an empty load clears valid.
    always_comb begin
        out_nxt_s = out_r;
        if (issue_s[0]) begin
            out_nxt_s = {1'b1, 1'b0, pend_idx_s[0], data_r[0][pend_idx_s[0]], addr_r[0][pend_idx_s[0]]};
        end else if (issue_s[1]) begin
            out_nxt_s = {1'b1, 1'b1, pend_idx_s[1], data_r[1][pend_idx_s[1]], addr_r[1][pend_idx_s[1]]};
        end else if (load_s) begin
            out_nxt_s = {OUT_W{1'b0}};
        end else begin
            out_nxt_s = out_r;
        end
    end

    // Per-entry lifecycle FREE -> PENDING -> ISSUED -> FREE.
    always_comb begin
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_nxt_s[t][i] = ST_FREE;
                case (state_r[t][i])
                    ST_FREE:    state_nxt_s[t][i] = (accept_s[t] && (free_idx_s[t] == IDX_W'(i))) ?
                                                    ST_PENDING : ST_FREE;
                    ST_PENDING: state_nxt_s[t][i] = (issue_s[t] && (pend_idx_s[t] == IDX_W'(i))) ?
                                                    ST_ISSUED : ST_PENDING;
                    ST_ISSUED:  state_nxt_s[t][i] = (comp_s[t] && (bus.index == IDX_W'(i))) ?
                                                    ST_FREE : ST_ISSUED;
                    default:    state_nxt_s[t][i] = ST_FREE;
                endcase
            end
        end
    end

    // Entry state, issue word and completion outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int t = 0; t < 2; t++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    state_r[t][i] <= ST_FREE;
                end
            end
            out_r        <= {OUT_W{1'b0}};
            read_done_r  <= 1'b0;
            write_done_r <= 1'b0;
            data_out_r   <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            out_r        <= out_nxt_s;
            read_done_r  <= comp_s[0];
            write_done_r <= comp_s[1];
            if (comp_s[0]) begin
                data_out_r <= bus.data_in;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    // Request payload; only meaningful while the entry is non-FREE, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int t = 0; t < 2; t++) begin
            if (accept_s[t]) begin
                data_r[t][free_idx_s[t]] <= bus.in_request_data;
                addr_r[t][free_idx_s[t]] <= bus.in_request_address;
            end
        end
    end

    assign bus.out_busy   = ~free_found_s;
    assign bus.out        = out_r;
    assign bus.read_done  = read_done_r;
    assign bus.write_done = write_done_r;
    assign bus.data_out   = data_out_r;
endmodule

// File: tb/tb_roce_front_end.sv
// Self-checking bench for roce_front_end: directed vector table, hand-written corner
// sequences and randomized traffic against an entry-list reference model.
module tb_roce_front_end;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    roce_front_end_if bus ();
    roce_front_end dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Reference model: 0=free 1=pending 2=issued per entry, table 0 reads, table 1 writes.
    int          m_st   [2][64];
    logic [31:0] m_data [2][64];
    logic [31:0] m_addr [2][64];
    logic [71:0] m_out;
    logic        m_rd, m_wr;
    logic [31:0] m_dout;

    typedef struct {
        logic v; logic t; logic [31:0] d; logic [31:0] a; logic g;
        logic dv; logic dt; logic [5:0] di; logic [31:0] din;
        logic [1:0] busy; logic ov; logic ot; logic [5:0] oi; logic [31:0] oa;
        logic rd; logic wr; logic [31:0] dout;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic t, input logic [31:0] d, input logic [31:0] a,
                         input logic g, input logic dv, input logic dt, input logic [5:0] di,
                         input logic [31:0] din);
        bus.in_valid = v; bus.in_request_type = t; bus.in_request_data = d;
        bus.in_request_address = a; bus.grant_i = g; bus.request_done_valid = dv;
        bus.the_type = dt; bus.index = di; bus.data_in = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < 64; i++) m_st[t][i] = 0;
        m_out = '0; m_rd = 1'b0; m_wr = 1'b0; m_dout = '0;
    endtask

    function automatic int lowest(input int t, input int s);
        for (int i = 0; i < 64; i++)
            if (m_st[t][i] == s) return i;
        return -1;
    endfunction

    // All decisions use the state before the edge, then are applied together.
    task automatic model_step();
        int  fi, ci, ct, dt, di, it;
        bit  hit, load;
        dt   = int'(bus.the_type);
        di   = int'(bus.index);
        it   = int'(bus.in_request_type);
        load = !m_out[71] || bus.grant_i;
        hit  = bus.request_done_valid && (m_st[dt][di] == 2);
        fi   = bus.in_valid ? lowest(it, 0) : -1;
        ct   = 0;
        ci   = lowest(0, 1);
        if (ci < 0) begin
            ci = lowest(1, 1);
            ct = 1;
        end
        m_rd = hit && (dt == 0);
        m_wr = hit && (dt == 1);
        if (m_rd) m_dout = bus.data_in;
        if (hit) m_st[dt][di] = 0;
        if (load) begin
            if (ci >= 0) begin
                m_st[ct][ci] = 2;
                m_out = {1'b1, ct[0], ci[5:0], m_data[ct][ci], m_addr[ct][ci]};
            end else begin
                m_out = '0;
            end
        end
        if (fi >= 0) begin
            m_st[it][fi]   = 1;
            m_data[it][fi] = bus.in_request_data;
            m_addr[it][fi] = bus.in_request_address;
        end
    endtask

    task automatic check_model();
        logic [71:0] act, exp;
        logic [1:0]  busy;
        act = bus.out;
        exp = m_out;
        if (!exp[70]) begin
            act[63:32] = '0;
            exp[63:32] = '0;
        end
        busy = {lowest(1, 0) < 0, lowest(0, 0) < 0};
        chk("rnd_out", act, exp);
        chk("rnd_busy", 72'(bus.out_busy), 72'(busy));
        chk("rnd_read_done", 72'(bus.read_done), 72'(m_rd));
        chk("rnd_write_done", 72'(bus.write_done), 72'(m_wr));
        chk("rnd_data_out", 72'(bus.data_out), 72'(m_dout));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #10;
        rst_n = 1'b0;
    endtask

    initial begin
        int q [$];
        int p_in, dt;
        logic [5:0] di;

        // Reset values
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #8;
        chk("reset_out", bus.out, 72'd0);
        chk("reset_busy", 72'(bus.out_busy), 72'd0);
        chk("reset_done", 72'({bus.read_done, bus.write_done}), 72'd0);
        chk("reset_data_out", 72'(bus.data_out), 72'd0);
        #2;
        rst_n = 1'b0;

        // Directed vector table
        tbl[0]  = '{1'b1, 1'b0, 32'h1,  32'h100, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0,  2'b00, 1'b0, 1'b0, 6'd0, 32'h0,   1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h22, 32'h200, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0,  2'b00, 1'b1, 1'b0, 6'd0, 32'h100, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h1,  32'h104, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0,  2'b00, 1'b1, 1'b0, 6'd0, 32'h100, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,  32'h0,   1'b1, 1'b0, 1'b0, 6'd0, 32'h0,  2'b00, 1'b1, 1'b0, 6'd1, 32'h104, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,  32'h0,   1'b1, 1'b0, 1'b0, 6'd0, 32'h0,  2'b00, 1'b1, 1'b1, 6'd0, 32'h200, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,  32'h0,   1'b1, 1'b1, 1'b0, 6'd0, 32'hA5, 2'b00, 1'b0, 1'b0, 6'd0, 32'h0,   1'b1, 1'b0, 32'hA5};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b1, 1'b0, 6'd0, 32'h77, 2'b00, 1'b0, 1'b0, 6'd0, 32'h0,   1'b0, 1'b0, 32'hA5};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b1, 1'b1, 6'd0, 32'h0,  2'b00, 1'b0, 1'b0, 6'd0, 32'h0,   1'b0, 1'b1, 32'hA5};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b1, 1'b1, 6'd5, 32'h0,  2'b00, 1'b0, 1'b0, 6'd0, 32'h0,   1'b0, 1'b0, 32'hA5};
        tbl[9]  = '{1'b1, 1'b0, 32'h3,  32'h108, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0,  2'b00, 1'b0, 1'b0, 6'd0, 32'h0,   1'b0, 1'b0, 32'hA5};
        tbl[10] = '{1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b0, 1'b0, 6'd0, 32'h0,  2'b00, 1'b1, 1'b0, 6'd0, 32'h108, 1'b0, 1'b0, 32'hA5};
        for (int r = 0; r < 11; r++) begin
            drive(tbl[r].v, tbl[r].t, tbl[r].d, tbl[r].a, tbl[r].g,
                  tbl[r].dv, tbl[r].dt, tbl[r].di, tbl[r].din);
            tick();
            chk("tbl_busy", 72'(bus.out_busy), 72'(tbl[r].busy));
            chk("tbl_out", 72'({bus.out[71:64], bus.out[31:0]}),
                72'({tbl[r].ov, tbl[r].ot, tbl[r].oi, tbl[r].oa}));
            chk("tbl_done", 72'({bus.read_done, bus.write_done}), 72'({tbl[r].rd, tbl[r].wr}));
            chk("tbl_data_out", 72'(bus.data_out), 72'(tbl[r].dout));
        end

        // Fill the read table, drop a 65th read, accept a write while reads are full
        do_reset();
        for (int i = 0; i < 64; i++) begin
            drive(1, 0, 32'd10, 32'd0, 0, 0, 0, 0, 0);
            tick();
        end
        chk("fill_busy", 72'(bus.out_busy), 72'(2'b01));
        drive(1, 0, 32'd10, 32'd0, 0, 0, 0, 0, 0);
        tick();
        chk("drop_busy", 72'(bus.out_busy), 72'(2'b01));
        chk("fill_out_head", 72'(bus.out[71:64]), 72'({1'b1, 1'b0, 6'd0}));
        drive(1, 1, 32'd10, 32'd0, 0, 0, 0, 0, 0);
        tick();
        chk("wr_while_full_busy", 72'(bus.out_busy), 72'(2'b01));
        chk("out_stable_no_grant", 72'(bus.out[71:64]), 72'({1'b1, 1'b0, 6'd0}));

        // Grant held: reads 1..63 in order, then the write, then nothing
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k < 64; k++) begin
            tick();
            chk("issue_order", 72'(bus.out[71:64]), 72'({1'b1, 1'b0, 6'(k)}));
        end
        tick();
        chk("issue_write", 72'(bus.out[71:0]), {1'b1, 1'b1, 6'd0, 32'd10, 32'd0});
        tick();
        chk("drain_empty", 72'(bus.out[71]), 72'd0);

        // Read completion, held notification acted on once, slot reallocated
        drive(0, 0, 0, 0, 0, 1, 0, 6'd0, 32'hA5);
        tick();
        chk("rd_done_pulse", 72'({bus.read_done, bus.write_done}), 72'(2'b10));
        chk("rd_data_out", 72'(bus.data_out), 72'h0A5);
        chk("rd_busy_clear", 72'(bus.out_busy), 72'(2'b00));
        tick();
        chk("rd_done_once", 72'(bus.read_done), 72'd0);
        chk("data_out_hold", 72'(bus.data_out), 72'h0A5);
        drive(1, 0, 32'd10, 32'h40, 0, 0, 0, 0, 0);
        tick();
        chk("realloc_busy", 72'(bus.out_busy), 72'(2'b01));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("realloc_idx0", 72'({bus.out[71:64], bus.out[31:0]}), 72'({1'b1, 1'b0, 6'd0, 32'h40}));

        // Slot freed on this edge is still full for an accept on the same edge
        drive(1, 0, 32'd10, 32'h44, 0, 1, 0, 6'd1, 32'h5A);
        tick();
        chk("same_edge_rd_done", 72'(bus.read_done), 72'd1);
        chk("same_edge_busy", 72'(bus.out_busy), 72'(2'b00));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("same_edge_dropped", 72'(bus.out_busy), 72'(2'b00));

        // Spurious write completion, then a real one
        drive(0, 0, 0, 0, 0, 1, 1, 6'd3, 0);
        tick();
        chk("spurious_wr", 72'(bus.write_done), 72'd0);
        drive(0, 0, 0, 0, 0, 1, 1, 6'd0, 0);
        tick();
        chk("wr_done_pulse", 72'(bus.write_done), 72'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("wr_done_once", 72'(bus.write_done), 72'd0);

        // Reset in the middle of a done pulse
        drive(0, 0, 0, 0, 0, 1, 0, 6'd2, 32'h33);
        tick();
        chk("pre_reset_rd_done", 72'(bus.read_done), 72'd1);
        #2;
        rst_n = 1'b1;
        #1;
        chk("midreset_out", bus.out, 72'd0);
        chk("midreset_busy", 72'(bus.out_busy), 72'd0);
        chk("midreset_done", 72'({bus.read_done, bus.write_done}), 72'd0);
        chk("midreset_data_out", 72'(bus.data_out), 72'd0);

        // Randomized traffic against the model, alternating fill-heavy and drain-heavy windows
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            p_in = ((c % 1000) < 500) ? 92 : 25;
            dt   = int'($urandom_range(0, 1));
            q.delete();
            for (int i = 0; i < 64; i++)
                if (m_st[dt][i] == 2) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 9) < 8)
                di = 6'(q[$urandom_range(0, q.size() - 1)]);
            else
                di = 6'($urandom_range(0, 63));
            drive($urandom_range(0, 99) < p_in, 1'($urandom_range(0, 1)), $urandom, $urandom,
                  $urandom_range(0, 99) < 40, $urandom_range(0, 99) < ((c % 1000) < 500 ? 15 : 60),
                  1'(dt), di, $urandom);
            model_step();
            tick();
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
